// File: rtl/cv32e40p_wb_arbiter.sv
// Register-file write-back arbiter: NUM_CH result channels, each with a DEPTH-entry FIFO and bypass.
// Define WB_ARB_PERF_EN to build the saturating stall-cycle counter on perf_stall_cnt_o.
module cv32e40p_wb_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int ARB_RR = 1,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_valid_i,
  output logic [NUM_CH-1:0]          ch_ready_o,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_waddr_i,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata_i,
  input  logic                       flush_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [ADDR_W-1:0]          wb_waddr_o,
  output logic [DATA_W-1:0]          wb_wdata_o,
  output logic [$clog2(NUM_CH)-1:0]  wb_ch_o,
  output logic                       busy_o,
  output logic                       contention_o,
  output logic [CNT_W-1:0]           perf_stall_cnt_o
);

  localparam int IW = $clog2(NUM_CH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_addrMem [NUM_CH][DEPTH];
  logic [DATA_W-1:0] r_dataMem [NUM_CH][DEPTH];
  logic [PW-1:0]     r_head    [NUM_CH];
  logic [PW-1:0]     r_tail    [NUM_CH];
  logic [CW-1:0]     r_count   [NUM_CH];
  logic [IW-1:0]     r_rrPtr;

  logic [NUM_CH-1:0] w_nonEmpty;
  logic [NUM_CH-1:0] w_ready;
  logic [NUM_CH-1:0] w_accept;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_grant;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_enq;
  logic [ADDR_W-1:0] w_headAddr [NUM_CH];
  logic [DATA_W-1:0] w_headData [NUM_CH];
  logic [IW-1:0]     w_grantIdx;
  logic              w_found;
  int                w_searchIdx;
  logic              w_xfer;

  function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on stored occupancy, so a popping full FIFO still reports not-ready.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_nonEmpty[i] = (r_count[i] != '0);
      w_ready[i]    = (r_count[i] < CW'(DEPTH));
      w_accept[i]   = ch_valid_i[i] & w_ready[i] & ~flush_i;
      w_req[i]      = w_nonEmpty[i] | (ch_valid_i[i] & w_ready[i]);
      w_headAddr[i] = w_nonEmpty[i] ? r_addrMem[i][r_head[i]] : ch_waddr_i[i*ADDR_W +: ADDR_W];
      w_headData[i] = w_nonEmpty[i] ? r_dataMem[i][r_head[i]] : ch_wdata_i[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_grant     = '0;
    w_grantIdx  = '0;
    w_found     = 1'b0;
    w_searchIdx = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_searchIdx = (ARB_RR != 0) ? (int'(r_rrPtr) + k) : k;
      if (w_searchIdx >= NUM_CH) w_searchIdx = w_searchIdx - NUM_CH;
      if (!w_found && w_req[w_searchIdx]) begin
        w_found              = 1'b1;
        w_grant[w_searchIdx] = 1'b1;
        w_grantIdx           = IW'(w_searchIdx);
      end
    end
  end

  assign ch_ready_o   = w_ready;
  assign wb_valid_o   = (|w_req) & ~flush_i;
  assign wb_waddr_o   = wb_valid_o ? w_headAddr[w_grantIdx] : '0;
  assign wb_wdata_o   = wb_valid_o ? w_headData[w_grantIdx] : '0;
  assign wb_ch_o      = wb_valid_o ? w_grantIdx : '0;
  assign busy_o       = |w_nonEmpty;
  assign contention_o = ($countones(w_req) >= 2);
  assign w_xfer       = wb_valid_o & wb_ready_i;

  // A bypassed result that is written this cycle never touches its FIFO.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop[i] = w_xfer & w_grant[i] & w_nonEmpty[i];
      w_enq[i] = w_accept[i] & ~(w_xfer & w_grant[i] & ~w_nonEmpty[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
        r_count[i] <= '0;
      end
      r_rrPtr <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
        r_count[i] <= '0;
      end
      r_rrPtr <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_enq[i]) r_tail[i] <= ptrNext(r_tail[i]);
        if (w_pop[i]) r_head[i] <= ptrNext(r_head[i]);
        if (w_enq[i] && !w_pop[i]) r_count[i] <= r_count[i] + 1'b1;
        else if (!w_enq[i] && w_pop[i]) r_count[i] <= r_count[i] - 1'b1;
      end
      if (w_xfer && (ARB_RR != 0))
        r_rrPtr <= (w_grantIdx == IW'(NUM_CH - 1)) ? '0 : w_grantIdx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_enq[i]) begin
        r_addrMem[i][r_tail[i]] <= ch_waddr_i[i*ADDR_W +: ADDR_W];
        r_dataMem[i][r_tail[i]] <= ch_wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [CNT_W-1:0] r_stallCnt;
  logic             w_stall;

  // Flush cycles are not stalls: nothing is eligible to be written while flushing.
  assign w_stall = ~flush_i & ((|(w_req & ~w_grant)) | (wb_valid_o & ~wb_ready_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stallCnt <= '0;
    else if (w_stall && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 1'b1;
  end

  assign perf_stall_cnt_o = r_stallCnt;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_wb_arbiter.sv
// Directed testbench for cv32e40p_wb_arbiter: fixed-priority and round-robin instances share stimulus.
// With WB_ARB_PERF_EN defined, an extra CNT_W=2 instance exercises counter saturation.
module tb_cv32e40p_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   chValid;
  logic [23:0]  chWaddr;
  logic [127:0] chWdata;
  logic         flush;
  logic         wbReady;

  logic [3:0]  fReady, rReady, sReady;
  logic        fWbValid, rWbValid, sWbValid;
  logic [5:0]  fAddr, rAddr, sAddr;
  logic [31:0] fData, rData, sData;
  logic [1:0]  fCh, rCh, sCh;
  logic        fBusy, rBusy, sBusy;
  logic        fCont, rCont, sCont;
  logic [15:0] fPerf, rPerf;
  logic [1:0]  sPerf;

  int errors = 0;
  int checks = 0;

  localparam logic [23:0]  K_ADDR = {6'd7, 6'd6, 6'd5, 6'd4};
  localparam logic [127:0] K_DATA = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

  cv32e40p_wb_arbiter #(.NUM_CH(4), .DEPTH(2), .ADDR_W(6), .DATA_W(32), .ARB_RR(0), .CNT_W(16)) dutFix (
    .clk(clk), .rst(rst), .ch_valid_i(chValid), .ch_ready_o(fReady), .ch_waddr_i(chWaddr),
    .ch_wdata_i(chWdata), .flush_i(flush), .wb_valid_o(fWbValid), .wb_ready_i(wbReady),
    .wb_waddr_o(fAddr), .wb_wdata_o(fData), .wb_ch_o(fCh), .busy_o(fBusy),
    .contention_o(fCont), .perf_stall_cnt_o(fPerf));

  cv32e40p_wb_arbiter #(.NUM_CH(4), .DEPTH(2), .ADDR_W(6), .DATA_W(32), .ARB_RR(1), .CNT_W(16)) dutRr (
    .clk(clk), .rst(rst), .ch_valid_i(chValid), .ch_ready_o(rReady), .ch_waddr_i(chWaddr),
    .ch_wdata_i(chWdata), .flush_i(flush), .wb_valid_o(rWbValid), .wb_ready_i(wbReady),
    .wb_waddr_o(rAddr), .wb_wdata_o(rData), .wb_ch_o(rCh), .busy_o(rBusy),
    .contention_o(rCont), .perf_stall_cnt_o(rPerf));

  cv32e40p_wb_arbiter #(.NUM_CH(4), .DEPTH(2), .ADDR_W(6), .DATA_W(32), .ARB_RR(1), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .ch_valid_i(chValid), .ch_ready_o(sReady), .ch_waddr_i(chWaddr),
    .ch_wdata_i(chWdata), .flush_i(flush), .wb_valid_o(sWbValid), .wb_ready_i(wbReady),
    .wb_waddr_o(sAddr), .wb_wdata_o(sData), .wb_ch_o(sCh), .busy_o(sBusy),
    .contention_o(sCont), .perf_stall_cnt_o(sPerf));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic        flush;
    logic        wbReady;
    logic        expValid;
    logic [5:0]  expAddr;
    logic [31:0] expData;
    logic [1:0]  expCh;
    logic        expCont;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 unit later.
  task automatic applyStimulus(input logic [3:0] valid, input logic fl, input logic rdy,
                               input logic [23:0] addrAll, input logic [127:0] dataAll);
    @(negedge clk);
    chValid = valid;
    flush   = fl;
    wbReady = rdy;
    chWaddr = addrAll;
    chWdata = dataAll;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    chValid = '0;
    flush   = 1'b0;
    wbReady = 1'b1;
    chWaddr = K_ADDR;
    chWdata = K_DATA;
    rst     = 1'b1;
    #1;
    rst     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pend [4];
    int seq  [4];
    int wr   [4];
    int rrModel;
    int expCh;
    int guard;
    int cyc;
    logic anyReq;
    logic [3:0] mReady;
    logic [3:0] mReq;
    logic [3:0] v;
    logic [23:0] a;
    logic [127:0] d;
    logic [31:0] bd;

    rst = 1'b1; chValid = '0; flush = 1'b0; wbReady = 1'b1; chWaddr = K_ADDR; chWdata = K_DATA;
    #1;
    checkOutput("reset_ready", 64'(fReady), 64'hF);
    checkOutput("reset_busy", 64'(fBusy), 64'h0);
    checkOutput("reset_wbvalid", 64'(rWbValid), 64'h0);
    checkOutput("reset_perf", 64'(fPerf), 64'h0);

    vecs[0] = '{4'b0000, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0,          2'd0, 1'b0};
    vecs[1] = '{4'b0010, 1'b0, 1'b1, 1'b1, 6'd5, 32'hA5A5_0001, 2'd1, 1'b0};
    vecs[2] = '{4'b0101, 1'b0, 1'b1, 1'b1, 6'd4, 32'hA5A5_0000, 2'd0, 1'b1};
    vecs[3] = '{4'b1000, 1'b0, 1'b1, 1'b1, 6'd7, 32'hA5A5_0003, 2'd3, 1'b0};
    vecs[4] = '{4'b0100, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0,          2'd0, 1'b0};
    vecs[5] = '{4'b1111, 1'b0, 1'b0, 1'b1, 6'd4, 32'hA5A5_0000, 2'd0, 1'b1};
    vecs[6] = '{4'b1100, 1'b0, 1'b1, 1'b1, 6'd6, 32'hA5A5_0002, 2'd2, 1'b1};

    // From the empty state both arbiters must pick the lowest requesting index.
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      chValid = vecs[n].valid;
      flush   = vecs[n].flush;
      wbReady = vecs[n].wbReady;
      #1;
      checkOutput($sformatf("vec%0d_fix_valid", n), 64'(fWbValid), 64'(vecs[n].expValid));
      checkOutput($sformatf("vec%0d_fix_addr", n),  64'(fAddr),    64'(vecs[n].expAddr));
      checkOutput($sformatf("vec%0d_fix_data", n),  64'(fData),    64'(vecs[n].expData));
      checkOutput($sformatf("vec%0d_fix_ch", n),    64'(fCh),      64'(vecs[n].expCh));
      checkOutput($sformatf("vec%0d_fix_cont", n),  64'(fCont),    64'(vecs[n].expCont));
      checkOutput($sformatf("vec%0d_fix_ready", n), 64'(fReady),   64'hF);
      checkOutput($sformatf("vec%0d_rr_valid", n),  64'(rWbValid), 64'(vecs[n].expValid));
      checkOutput($sformatf("vec%0d_rr_data", n),   64'(rData),    64'(vecs[n].expData));
      checkOutput($sformatf("vec%0d_rr_ch", n),     64'(rCh),      64'(vecs[n].expCh));
      chValid = '0;
      flush   = 1'b0;
      rst     = 1'b1;
      #1;
      rst     = 1'b0;
    end

    // Bypass: written the cycle it is presented, nothing left buffered.
    doReset();
    applyStimulus(4'b0010, 1'b0, 1'b1, K_ADDR, K_DATA);
    checkOutput("bypass_valid", 64'(fWbValid), 64'h1);
    checkOutput("bypass_addr", 64'(fAddr), 64'd5);
    checkOutput("bypass_ch", 64'(fCh), 64'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1, K_ADDR, K_DATA);
    checkOutput("bypass_busy", 64'(fBusy), 64'h0);
    checkOutput("bypass_busy_rr", 64'(rBusy), 64'h0);

    // Fixed-priority contention: ch0 bypasses, ch2 is buffered and written next cycle.
    doReset();
    applyStimulus(4'b0101, 1'b0, 1'b1, K_ADDR, K_DATA);
    checkOutput("fix_c0_valid", 64'(fWbValid), 64'h1);
    checkOutput("fix_c0_ch", 64'(fCh), 64'd0);
    checkOutput("fix_c0_data", 64'(fData), 64'hA5A5_0000);
    checkOutput("fix_c0_cont", 64'(fCont), 64'h1);
    checkOutput("fix_c0_busy", 64'(fBusy), 64'h0);
    applyStimulus(4'b0000, 1'b0, 1'b1, K_ADDR, K_DATA);
    checkOutput("fix_c1_valid", 64'(fWbValid), 64'h1);
    checkOutput("fix_c1_ch", 64'(fCh), 64'd2);
    checkOutput("fix_c1_data", 64'(fData), 64'hA5A5_0002);
    checkOutput("fix_c1_addr", 64'(fAddr), 64'd6);
    checkOutput("fix_c1_cont", 64'(fCont), 64'h0);
    checkOutput("fix_c1_busy", 64'(fBusy), 64'h1);
`ifdef WB_ARB_PERF_EN
    checkOutput("fix_perf", 64'(fPerf), 64'd1);
`else
    checkOutput("fix_perf", 64'(fPerf), 64'd0);
`endif
    applyStimulus(4'b0000, 1'b0, 1'b1, K_ADDR, K_DATA);
    checkOutput("fix_c2_busy", 64'(fBusy), 64'h0);
    checkOutput("fix_c2_valid", 64'(fWbValid), 64'h0);

    // Backpressure on ch3: two results fill the FIFO, the third waits at the source.
    doReset();
    for (int k = 0; k < 7; k++) begin
      v  = (k < 5) ? 4'b1000 : 4'b0000;
      bd = 32'hB000_0000 + 32'((k < 2) ? k : 2);
      a  = {6'(10 + ((k < 2) ? k : 2)), 18'h0};
      applyStimulus(v, 1'b0, (k >= 3), a, {bd, 96'h0});
      case (k)
        0: begin
          checkOutput("bp_c0_ready", 64'(rReady[3]), 64'h1);
          checkOutput("bp_c0_data", 64'(rData), 64'hB000_0000);
          checkOutput("bp_c0_ch", 64'(rCh), 64'd3);
        end
        1: begin
          checkOutput("bp_c1_ready", 64'(rReady[3]), 64'h1);
          checkOutput("bp_c1_data", 64'(rData), 64'hB000_0000);
          checkOutput("bp_c1_busy", 64'(rBusy), 64'h1);
        end
        2: begin
          checkOutput("bp_c2_ready", 64'(rReady[3]), 64'h0);
          checkOutput("bp_c2_data", 64'(rData), 64'hB000_0000);
        end
        3: begin
          checkOutput("bp_c3_ready_full_pop", 64'(rReady[3]), 64'h0);
          checkOutput("bp_c3_valid", 64'(rWbValid), 64'h1);
          checkOutput("bp_c3_addr", 64'(rAddr), 64'd10);
        end
        4: begin
          checkOutput("bp_c4_ready", 64'(rReady[3]), 64'h1);
          checkOutput("bp_c4_data", 64'(rData), 64'hB000_0001);
          checkOutput("bp_c4_addr", 64'(rAddr), 64'd11);
        end
        5: begin
          checkOutput("bp_c5_data", 64'(rData), 64'hB000_0002);
          checkOutput("bp_c5_addr", 64'(rAddr), 64'd12);
        end
        default: begin
          checkOutput("bp_c6_busy", 64'(rBusy), 64'h0);
          checkOutput("bp_c6_valid", 64'(rWbValid), 64'h0);
        end
      endcase
    end

    // Round-robin with all channels saturated, then drained; checked against an occupancy model.
    doReset();
    for (int i = 0; i < 4; i++) begin
      pend[i] = 0;
      seq[i]  = 0;
      wr[i]   = 0;
    end
    rrModel = 0;
    guard   = 0;
    cyc     = 0;
    while ((cyc < 12 || (pend[0] + pend[1] + pend[2] + pend[3]) != 0) && guard < 40) begin
      v = (cyc < 12) ? 4'b1111 : 4'b0000;
      for (int i = 0; i < 4; i++) begin
        a[i*6 +: 6]   = 6'(i);
        d[i*32 +: 32] = 32'hC000_0000 | (32'(i) << 16) | 32'(seq[i]);
        mReady[i]     = (pend[i] < 2);
        mReq[i]       = (pend[i] > 0) | v[i];
      end
      expCh  = 0;
      anyReq = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!anyReq && mReq[(rrModel + k) % 4]) begin
          anyReq = 1'b1;
          expCh  = (rrModel + k) % 4;
        end
      end
      applyStimulus(v, 1'b0, 1'b1, a, d);
      checkOutput($sformatf("rr_c%0d_ready", cyc), 64'(rReady), 64'(mReady));
      if (cyc == 2) checkOutput("rr_c2_ready_full", 64'(rReady), 64'b0011);
      checkOutput($sformatf("rr_c%0d_valid", cyc), 64'(rWbValid), 64'(anyReq));
      if (anyReq) begin
        checkOutput($sformatf("rr_c%0d_ch", cyc), 64'(rCh), 64'(expCh));
        checkOutput($sformatf("rr_c%0d_data", cyc), 64'(rData),
                    64'(32'hC000_0000 | (32'(expCh) << 16) | 32'(wr[expCh])));
      end
      for (int i = 0; i < 4; i++) begin
        if (v[i] && mReady[i]) begin
          seq[i]++;
          pend[i]++;
        end
      end
      if (anyReq) begin
        wr[expCh]++;
        pend[expCh]--;
        rrModel = (expCh + 1) % 4;
      end
      cyc++;
      guard++;
    end
    checkOutput("rr_drain_done", 64'(pend[0] + pend[1] + pend[2] + pend[3]), 64'h0);
    applyStimulus(4'b0000, 1'b0, 1'b1, K_ADDR, K_DATA);
    checkOutput("rr_drain_busy", 64'(rBusy), 64'h0);

    // Flush discards buffered entries and blocks the incoming ch0 result.
    doReset();
    applyStimulus(4'b0011, 1'b0, 1'b0, K_ADDR, K_DATA);
    applyStimulus(4'b0001, 1'b1, 1'b1, K_ADDR, K_DATA);
    checkOutput("flush_busy_before", 64'(fBusy), 64'h1);
    checkOutput("flush_wbvalid", 64'(fWbValid), 64'h0);
    applyStimulus(4'b0000, 1'b0, 1'b1, K_ADDR, K_DATA);
    checkOutput("flush_busy_after", 64'(fBusy), 64'h0);
    checkOutput("flush_ready_after", 64'(fReady), 64'hF);
    checkOutput("flush_wbvalid_after", 64'(fWbValid), 64'h0);

    // Asynchronous reset drops buffered results without a clock edge.
    applyStimulus(4'b0011, 1'b0, 1'b0, K_ADDR, K_DATA);
    applyStimulus(4'b0000, 1'b0, 1'b0, K_ADDR, K_DATA);
    checkOutput("areset_busy_before", 64'(fBusy), 64'h1);
    rst = 1'b1;
    #1;
    checkOutput("areset_busy", 64'(fBusy), 64'h0);
    checkOutput("areset_ready", 64'(fReady), 64'hF);
    rst = 1'b0;

`ifdef WB_ARB_PERF_EN
    doReset();
    for (int k = 0; k < 5; k++) applyStimulus(4'b0011, 1'b0, 1'b1, K_ADDR, K_DATA);
    applyStimulus(4'b0000, 1'b1, 1'b1, K_ADDR, K_DATA);
    checkOutput("perf_count5", 64'(fPerf), 64'd5);
    checkOutput("perf_saturate", 64'(sPerf), 64'd3);
    applyStimulus(4'b0000, 1'b0, 1'b1, K_ADDR, K_DATA);
    checkOutput("perf_after_flush", 64'(fPerf), 64'd5);
    doReset();
    #1;
    checkOutput("perf_after_rst", 64'(fPerf), 64'd0);
`else
    checkOutput("perf_absent", 64'(sPerf), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
